// File: rtl/lsq_pkg.sv
// Shared encodings for the load/store queue: funct3 load/store codes,
// memory access sizes and the memory-side FSM states.
package lsq_pkg;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

   typedef enum logic [0:0] {
      LSQ_IDLE = 1'b0,
      LSQ_WAIT = 1'b1
   } lsq_state_e;

endpackage

// File: rtl/lsq_load_ext.sv
// Selects the addressed byte/half of an aligned memory word and sign- or
// zero-extends it according to the load funct3.
module lsq_load_ext
   import lsq_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      funct3,
   input  logic [1:0]      offset,
   input  logic [XLEN-1:0] word,
   output logic [XLEN-1:0] value
);

   logic [XLEN-1:0] byte_shift_s;
   logic [XLEN-1:0] half_shift_s;
   logic [7:0]      byte_s;
   logic [15:0]     half_s;

   // Lane select and extension
   always_comb begin
      byte_shift_s = word >> {offset, 3'b000};
      half_shift_s = word >> {offset[1], 4'b0000};
      byte_s       = byte_shift_s[7:0];
      half_s       = half_shift_s[15:0];
      case (funct3)
         F3_B:    value = {{(XLEN-8){byte_s[7]}}, byte_s};
         F3_H:    value = {{(XLEN-16){half_s[15]}}, half_s};
         F3_BU:   value = {{(XLEN-8){1'b0}}, byte_s};
         F3_HU:   value = {{(XLEN-16){1'b0}}, half_s};
         F3_W:    value = word;
         default: value = word;
      endcase
   end

endmodule

// File: rtl/load_store_queue.sv
// In-order load/store queue: CAM-updated circular buffer that issues one
// memory operation at a time from the head; stores wait for ROB commit.
module load_store_queue
   import lsq_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int ROB_W = 5,
   parameter int XLEN  = 32
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             rdy_in,
   input  logic             _clear,
   input  logic             _ls_ready,
   input  logic [3:0]       _ls_type,
   input  logic [ROB_W-1:0] _ls_rob_id,
   output logic             _ls_full,
   input  logic             _lsb_rs_ready,
   input  logic [ROB_W-1:0] _lsb_rs_rob_id,
   input  logic [XLEN-1:0]  _lsb_rs_st_value,
   input  logic             _lsb_alu_ready,
   input  logic [ROB_W-1:0] _alu_rob_id,
   input  logic [XLEN-1:0]  _alu_value,
   input  logic             _rob_commit_ready,
   input  logic [ROB_W-1:0] _rob_commit_id,
   output logic             _mem_req,
   output logic             _r_nw_in,
   output logic [XLEN-1:0]  _addr,
   output logic [XLEN-1:0]  _data_in,
   output logic [1:0]       _mem_size,
   input  logic             _mem_done,
   input  logic [XLEN-1:0]  _data_out,
   output logic             _lsb_cdb_ready,
   output logic [ROB_W-1:0] _lsb_cdb_rob_id,
   output logic [XLEN-1:0]  _lsb_cdb_value
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DEPTH-1:0] valid_r, is_store_r, addr_rdy_r, data_rdy_r, committed_r;
   logic [2:0]       funct3_r [DEPTH];
   logic [ROB_W-1:0] rob_id_r [DEPTH];
   logic [XLEN-1:0]  addr_r   [DEPTH];
   logic [XLEN-1:0]  data_r   [DEPTH];

   logic [PTR_W-1:0] head_r, tail_r;
   logic [CNT_W-1:0] count_r;
   lsq_state_e       state_r, state_nx_s;
   logic             killed_r;

   logic             mem_req_r, r_nw_r, cdb_ready_r;
   logic [XLEN-1:0]  mem_addr_r, mem_data_r, cdb_value_r;
   logic [1:0]       mem_size_r;
   logic [ROB_W-1:0] cdb_rob_r;

   logic [DEPTH-1:0] addr_hit_s, data_hit_s, commit_hit_s;
   logic [DEPTH-1:0] addr_rdy_upd_s, data_rdy_upd_s, committed_upd_s;
   logic [DEPTH-1:0] head_oh_s, tail_oh_s, pop_mask_s, push_mask_s, valid_nx_s;
   logic [XLEN-1:0]  head_addr_s, head_data_s, ext_value_s;
   logic [CNT_W-1:0] keep_cnt_s, count_nx_s;
   logic [PTR_W-1:0] head_nx_s, tail_nx_s;
   logic             issue_s, done_s, pop_s, push_s, cdb_fire_s, killed_nx_s;

   assign _ls_full        = (count_r == CNT_W'(DEPTH));
   assign _mem_req        = mem_req_r;
   assign _r_nw_in        = r_nw_r;
   assign _addr           = mem_addr_r;
   assign _data_in        = mem_data_r;
   assign _mem_size       = mem_size_r;
   assign _lsb_cdb_ready  = cdb_ready_r;
   assign _lsb_cdb_rob_id = cdb_rob_r;
   assign _lsb_cdb_value  = cdb_value_r;

   // CAM match of the three result ports against every live entry
   always_comb begin
      addr_hit_s   = '0;
      data_hit_s   = '0;
      commit_hit_s = '0;
      for (int i = 0; i < DEPTH; i++) begin
         addr_hit_s[i]   = valid_r[i] && _lsb_alu_ready    && (rob_id_r[i] == _alu_rob_id);
         data_hit_s[i]   = valid_r[i] && _lsb_rs_ready     && (rob_id_r[i] == _lsb_rs_rob_id);
         commit_hit_s[i] = valid_r[i] && _rob_commit_ready && (rob_id_r[i] == _rob_commit_id);
      end
      addr_rdy_upd_s  = addr_rdy_r  | addr_hit_s;
      data_rdy_upd_s  = data_rdy_r  | data_hit_s;
      committed_upd_s = committed_r | commit_hit_s;
   end

   // Issue/completion decisions; head fields are forwarded so a same-cycle CAM hit can issue
   always_comb begin
      head_addr_s = addr_hit_s[head_r] ? _alu_value : addr_r[head_r];
      head_data_s = data_hit_s[head_r] ? _lsb_rs_st_value : data_r[head_r];
      issue_s     = (state_r == LSQ_IDLE) && !_clear && valid_r[head_r] && addr_rdy_upd_s[head_r]
                    && (!is_store_r[head_r] || (data_rdy_upd_s[head_r] && committed_upd_s[head_r]));
      done_s      = (state_r == LSQ_WAIT) && _mem_done;
      pop_s       = done_s && !killed_r;
      push_s      = _ls_ready && !_ls_full && !_clear;
      cdb_fire_s  = pop_s && !is_store_r[head_r] && !_clear;
      if (done_s) begin
         killed_nx_s = 1'b0;
      end else if (_clear && (state_r == LSQ_WAIT) && !committed_upd_s[head_r]) begin
         killed_nx_s = 1'b1;
      end else begin
         killed_nx_s = killed_r;
      end
   end

   // Pointer, count and valid-vector update including the flush rebuild
   always_comb begin
      head_oh_s   = {{(DEPTH-1){1'b0}}, 1'b1} << head_r;
      tail_oh_s   = {{(DEPTH-1){1'b0}}, 1'b1} << tail_r;
      pop_mask_s  = pop_s  ? head_oh_s : '0;
      push_mask_s = push_s ? tail_oh_s : '0;
      keep_cnt_s  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_r[i] && committed_upd_s[i] && !(pop_s && (PTR_W'(i) == head_r))) begin
            keep_cnt_s = keep_cnt_s + CNT_W'(1);
         end else begin
            keep_cnt_s = keep_cnt_s;
         end
      end
      head_nx_s = head_r + PTR_W'(pop_s);
      if (_clear) begin
         // committed entries are a contiguous run starting at the head
         valid_nx_s = valid_r & ~pop_mask_s & committed_upd_s;
         count_nx_s = keep_cnt_s;
         tail_nx_s  = head_nx_s + keep_cnt_s[PTR_W-1:0];
      end else begin
         valid_nx_s = (valid_r & ~pop_mask_s) | push_mask_s;
         count_nx_s = count_r - CNT_W'(pop_s) + CNT_W'(push_s);
         tail_nx_s  = tail_r + PTR_W'(push_s);
      end
   end

   // Memory handshake FSM next state
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         LSQ_IDLE: state_nx_s = issue_s ? LSQ_WAIT : LSQ_IDLE;
         LSQ_WAIT: state_nx_s = _mem_done ? LSQ_IDLE : LSQ_WAIT;
         default:  state_nx_s = LSQ_IDLE;
      endcase
   end

   lsq_load_ext #(.XLEN(XLEN)) u_load_ext (
      .funct3 (funct3_r[head_r]),
      .offset (mem_addr_r[1:0]),
      .word   (_data_out),
      .value  (ext_value_s)
   );

   // Entry storage
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         valid_r     <= '0;
         is_store_r  <= '0;
         addr_rdy_r  <= '0;
         data_rdy_r  <= '0;
         committed_r <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            funct3_r[i] <= 3'd0;
            rob_id_r[i] <= '0;
            addr_r[i]   <= '0;
            data_r[i]   <= '0;
         end
      end else if (rdy_in) begin
         valid_r     <= valid_nx_s;
         addr_rdy_r  <= addr_rdy_upd_s  & ~push_mask_s;
         data_rdy_r  <= data_rdy_upd_s  & ~push_mask_s;
         committed_r <= committed_upd_s & ~push_mask_s;
         for (int i = 0; i < DEPTH; i++) begin
            if (addr_hit_s[i]) addr_r[i] <= _alu_value;
            if (data_hit_s[i]) data_r[i] <= _lsb_rs_st_value;
         end
         if (push_s) begin
            is_store_r[tail_r] <= _ls_type[3];
            funct3_r[tail_r]   <= _ls_type[2:0];
            rob_id_r[tail_r]   <= _ls_rob_id;
         end
      end
   end

   // Queue pointers and FSM state
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         head_r   <= '0;
         tail_r   <= '0;
         count_r  <= '0;
         state_r  <= LSQ_IDLE;
         killed_r <= 1'b0;
      end else if (rdy_in) begin
         head_r   <= head_nx_s;
         tail_r   <= tail_nx_s;
         count_r  <= count_nx_s;
         state_r  <= state_nx_s;
         killed_r <= killed_nx_s;
      end
   end

   // Registered memory request and CDB outputs
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         mem_req_r   <= 1'b0;
         r_nw_r      <= 1'b0;
         mem_addr_r  <= '0;
         mem_data_r  <= '0;
         mem_size_r  <= 2'd0;
         cdb_ready_r <= 1'b0;
         cdb_rob_r   <= '0;
         cdb_value_r <= '0;
      end else if (rdy_in) begin
         cdb_ready_r <= cdb_fire_s;
         if (cdb_fire_s) begin
            cdb_rob_r   <= rob_id_r[head_r];
            cdb_value_r <= ext_value_s;
         end
         if (issue_s) begin
            mem_req_r  <= 1'b1;
            r_nw_r     <= !is_store_r[head_r];
            mem_addr_r <= head_addr_s;
            mem_data_r <= head_data_s;
            mem_size_r <= funct3_r[head_r][1:0];
         end else if (done_s) begin
            mem_req_r  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_load_store_queue.sv
// Directed bench for load_store_queue (DEPTH=4) with a queue-based reference
// model compared every cycle, plus literal checks for the documented scenarios.
module tb_load_store_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_in = 1'b1, rdy_in = 1'b1, clear = 1'b0;
   logic        ls_ready = 1'b0;
   logic [3:0]  ls_type = 4'd0;
   logic [4:0]  ls_rob = 5'd0;
   logic        ls_full;
   logic        rs_ready = 1'b0;
   logic [4:0]  rs_rob = 5'd0;
   logic [31:0] rs_val = 32'd0;
   logic        alu_ready = 1'b0;
   logic [4:0]  alu_rob = 5'd0;
   logic [31:0] alu_val = 32'd0;
   logic        cm_ready = 1'b0;
   logic [4:0]  cm_rob = 5'd0;
   logic        mem_req, r_nw;
   logic [31:0] mem_addr, mem_wdata;
   logic [1:0]  mem_size;
   logic        mem_done = 1'b0;
   logic [31:0] data_out = 32'd0;
   logic        cdb_ready;
   logic [4:0]  cdb_rob;
   logic [31:0] cdb_val;

   int n_cmp = 0, n_fail = 0;
   bit started = 1'b0;

   always #5 clk = ~clk;

   load_store_queue #(.DEPTH(DEPTH), .ROB_W(5), .XLEN(32)) dut (
      .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), ._clear(clear),
      ._ls_ready(ls_ready), ._ls_type(ls_type), ._ls_rob_id(ls_rob), ._ls_full(ls_full),
      ._lsb_rs_ready(rs_ready), ._lsb_rs_rob_id(rs_rob), ._lsb_rs_st_value(rs_val),
      ._lsb_alu_ready(alu_ready), ._alu_rob_id(alu_rob), ._alu_value(alu_val),
      ._rob_commit_ready(cm_ready), ._rob_commit_id(cm_rob),
      ._mem_req(mem_req), ._r_nw_in(r_nw), ._addr(mem_addr), ._data_in(mem_wdata),
      ._mem_size(mem_size), ._mem_done(mem_done), ._data_out(data_out),
      ._lsb_cdb_ready(cdb_ready), ._lsb_cdb_rob_id(cdb_rob), ._lsb_cdb_value(cdb_val)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic        st;
      logic [2:0]  f3;
      logic [4:0]  rob;
      logic [31:0] addr;
      logic        ardy;
      logic [31:0] data;
      logic        drdy;
      logic        comm;
   } ent_t;

   ent_t        q[$];
   bit          busy, killed, fl_load;
   logic [2:0]  fl_f3;
   logic [4:0]  fl_rob;
   logic [31:0] fl_addr;
   logic        e_req, e_rnw, e_cdb;
   logic [31:0] e_addr, e_data, e_cdb_val;
   logic [1:0]  e_size;
   logic [4:0]  e_cdb_rob;

   function automatic logic [31:0] ext(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
      logic [31:0] b, h;
      b = (w >> (8 * a[1:0])) & 32'hFF;
      h = (w >> (16 * a[1])) & 32'hFFFF;
      case (f3)
         3'd0:    return b[7]  ? (b | 32'hFFFF_FF00) : b;
         3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
         3'd4:    return b;
         3'd5:    return h;
         default: return w;
      endcase
   endfunction

   always @(posedge clk) begin
      if (rst_in) begin
         q.delete();
         busy = 0; killed = 0; fl_load = 0;
         e_req = 0; e_rnw = 0; e_addr = 0; e_data = 0; e_size = 0;
         e_cdb = 0; e_cdb_rob = 0; e_cdb_val = 0;
      end else if (rdy_in) begin : step
         int   n0;
         bit   was_busy;
         ent_t e;
         n0 = q.size();
         was_busy = busy;
         e_cdb = 0;
         if (busy && mem_done) begin
            busy = 0;
            e_req = 0;
            if (!killed) begin
               if (fl_load && !clear) begin
                  e_cdb = 1; e_cdb_rob = fl_rob; e_cdb_val = ext(fl_f3, fl_addr, data_out);
               end
               q.delete(0);
            end
            killed = 0;
         end
         foreach (q[i]) begin
            if (alu_ready && q[i].rob == alu_rob) begin q[i].addr = alu_val; q[i].ardy = 1; end
            if (rs_ready  && q[i].rob == rs_rob)  begin q[i].data = rs_val;  q[i].drdy = 1; end
            if (cm_ready  && q[i].rob == cm_rob)  q[i].comm = 1;
         end
         if (!was_busy && !clear && q.size() > 0 && q[0].ardy && (!q[0].st || (q[0].drdy && q[0].comm))) begin
            busy = 1; e_req = 1; e_rnw = !q[0].st; e_addr = q[0].addr; e_data = q[0].data;
            e_size = q[0].f3[1:0]; fl_load = !q[0].st; fl_f3 = q[0].f3; fl_rob = q[0].rob; fl_addr = q[0].addr;
         end
         if (clear) begin
            if (busy && fl_load && !killed) killed = 1;
            for (int i = q.size() - 1; i >= 0; i--) if (!q[i].comm) q.delete(i);
         end
         if (ls_ready && !clear && n0 < DEPTH) begin
            e.st = ls_type[3]; e.f3 = ls_type[2:0]; e.rob = ls_rob;
            e.addr = 0; e.ardy = 0; e.data = 0; e.drdy = 0; e.comm = 0;
            q.push_back(e);
         end
      end
   end

   // per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (started) begin
         chk("mem_req", mem_req, e_req);
         chk("ls_full", ls_full, (q.size() == DEPTH) ? 32'd1 : 32'd0);
         chk("cdb_ready", cdb_ready, e_cdb);
         if (e_req) begin
            chk("r_nw", r_nw, e_rnw);
            chk("addr", mem_addr, e_addr);
            chk("size", mem_size, e_size);
            if (!e_rnw) chk("wdata", mem_wdata, e_data);
         end
         if (e_cdb) begin
            chk("cdb_rob", cdb_rob, e_cdb_rob);
            chk("cdb_val", cdb_val, e_cdb_val);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic alloc(input logic [3:0] t, input logic [4:0] r);
      ls_ready = 1; ls_type = t; ls_rob = r; cyc(); ls_ready = 0;
   endtask

   task automatic alu(input logic [4:0] r, input logic [31:0] a);
      alu_ready = 1; alu_rob = r; alu_val = a; cyc(); alu_ready = 0;
   endtask

   task automatic respond(input logic [31:0] w);
      int k = 0;
      while (!mem_req && k < 20) begin cyc(); k++; end
      chk("req_timeout", mem_req, 1);
      mem_done = 1; data_out = w; cyc(); mem_done = 0;
   endtask

   task automatic serve_load(input logic [4:0] r, input logic [31:0] a, input logic [31:0] w);
      alu(r, a); respond(w);
   endtask

   logic [2:0]  lx_f3  [6] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd0, 3'd2};
   logic [31:0] lx_adr [6] = '{32'h101, 32'h101, 32'h102, 32'h102, 32'h103, 32'h104};
   logic [31:0] lx_wrd [6] = '{32'h0000_8000, 32'h0000_8000, 32'h8001_0000, 32'h8001_0000, 32'h7F00_0000, 32'hCAFE_F00D};
   logic [31:0] lx_exp [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001, 32'h0000_007F, 32'hCAFE_F00D};

   initial begin
      cyc(); started = 1; cyc(); cyc();
      chk("rst_req", mem_req, 0);
      chk("rst_full", ls_full, 0);
      chk("rst_cdb", cdb_ready, 0);
      chk("rst_addr", mem_addr, 0);
      rst_in = 0; cyc();

      // LW rob 3 at 0x100
      alloc(4'b0010, 5'd3);
      alu(5'd3, 32'h100);
      chk("lw_req", mem_req, 1);
      chk("lw_rnw", r_nw, 1);
      chk("lw_addr", mem_addr, 32'h100);
      respond(32'hDEAD_BEEF);
      chk("lw_cdb", cdb_ready, 1);
      chk("lw_rob", cdb_rob, 3);
      chk("lw_val", cdb_val, 32'hDEAD_BEEF);
      cyc();
      chk("lw_cdb_once", cdb_ready, 0);

      // load extension table
      for (int i = 0; i < 6; i++) begin
         alloc({1'b0, lx_f3[i]}, 5'(10 + i));
         serve_load(5'(10 + i), lx_adr[i], lx_wrd[i]);
         chk("lx_val", cdb_val, lx_exp[i]);
      end

      // SW rob 4 waits for commit
      alloc(4'b1010, 5'd4);
      alu_ready = 1; alu_rob = 5'd4; alu_val = 32'h200;
      rs_ready = 1; rs_rob = 5'd4; rs_val = 32'h1234_5678;
      cyc(); alu_ready = 0; rs_ready = 0;
      cyc(); cyc();
      chk("sw_nocommit", mem_req, 0);
      cm_ready = 1; cm_rob = 5'd4; cyc(); cm_ready = 0;
      chk("sw_req", mem_req, 1);
      chk("sw_rnw", r_nw, 0);
      chk("sw_data", mem_wdata, 32'h1234_5678);
      respond(32'd0);
      chk("sw_nocdb", cdb_ready, 0);

      // fill, overflow and wrap
      alloc(4'b0010, 5'd8); alloc(4'b0010, 5'd9); alloc(4'b0010, 5'd10); alloc(4'b0010, 5'd11);
      chk("full", ls_full, 1);
      alloc(4'b0010, 5'd12);
      serve_load(5'd8, 32'h400, 32'h1111_1111);
      chk("unfull", ls_full, 0);
      alloc(4'b0010, 5'd13);
      chk("refull", ls_full, 1);
      serve_load(5'd9, 32'h404, 32'h2222_2222);
      serve_load(5'd10, 32'h408, 32'h3333_3333);
      serve_load(5'd11, 32'h40C, 32'h4444_4444);
      serve_load(5'd13, 32'h410, 32'h5555_5555);
      chk("wrap_rob", cdb_rob, 13);

      // flush keeps the committed store only
      alloc(4'b1010, 5'd14); alloc(4'b0010, 5'd15); alloc(4'b0010, 5'd16);
      rs_ready = 1; rs_rob = 5'd14; rs_val = 32'hA5A5_A5A5;
      cm_ready = 1; cm_rob = 5'd14; cyc(); rs_ready = 0; cm_ready = 0;
      clear = 1; cyc(); clear = 0;
      alloc(4'b0010, 5'd17); alloc(4'b0010, 5'd18); alloc(4'b0010, 5'd19);
      chk("clr_full", ls_full, 1);
      alu(5'd14, 32'h300);
      chk("clr_st_req", mem_req, 1);
      chk("clr_st_rnw", r_nw, 0);
      chk("clr_st_addr", mem_addr, 32'h300);
      respond(32'd0);
      serve_load(5'd17, 32'h500, 32'h0000_0017);
      serve_load(5'd18, 32'h504, 32'h0000_0018);
      serve_load(5'd19, 32'h508, 32'h0000_0019);

      // load in flight at flush: completes silently
      alloc(4'b0010, 5'd20);
      alu(5'd20, 32'h600);
      clear = 1; cyc(); clear = 0;
      alloc(4'b0010, 5'd21);
      respond(32'h5A5A_5A5A);
      chk("kill_nocdb", cdb_ready, 0);
      serve_load(5'd21, 32'h604, 32'h2121_2121);
      chk("kill_next_rob", cdb_rob, 21);

      // SH with address, data and commit in one cycle, then a rdy_in stall
      alloc(4'b1001, 5'd22);
      alu_ready = 1; alu_rob = 5'd22; alu_val = 32'h700;
      rs_ready = 1; rs_rob = 5'd22; rs_val = 32'hBEEF_0022;
      cm_ready = 1; cm_rob = 5'd22;
      cyc(); alu_ready = 0; rs_ready = 0; cm_ready = 0;
      chk("tri_req", mem_req, 1);
      chk("tri_size", mem_size, 1);
      chk("tri_data", mem_wdata, 32'hBEEF_0022);
      rdy_in = 0; cyc(); cyc();
      chk("stall_req", mem_req, 1);
      rdy_in = 1;
      respond(32'd0);
      cyc(); cyc();
      chk("end_idle", mem_req, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/load_store_queue.md
# load_store_queue

Parametrised in-order load/store queue for the out-of-order RV32I core, replacing the fixed 32-entry load/store buffer. Sits between dispatch (InstFetcher), the address ALU, the LSB reservation station, the ROB commit port, the memory controller and the CDB. Holds memory operations in program order and issues them to memory one at a time from the head. Stores are issued only after ROB commit. Loads are sign- or zero-extended and broadcast on the CDB. Committed stores survive a pipeline flush.

## Interface
- `DEPTH`, 16: entry count; power of two, ≥2
- `ROB_W`, 5: ROB id width
- `XLEN`, 32: data/address width
- `clk_in` in 1: system clock
- `rst_in` in 1: synchronous, active-high reset
- `rdy_in` in 1: when low, all state holds and no output changes
- `_clear` in 1: mispredict flush
- `_ls_ready` in 1, `_ls_type` in 4 ([3]=store, [2:0]=funct3), `_ls_rob_id` in ROB_W: allocate
- `_ls_full` out 1: no allocation accepted this cycle
- `_lsb_rs_ready` in 1, `_lsb_rs_rob_id` in ROB_W, `_lsb_rs_st_value` in XLEN: store data
- `_lsb_alu_ready` in 1, `_alu_rob_id` in ROB_W, `_alu_value` in XLEN: effective address
- `_rob_commit_ready` in 1, `_rob_commit_id` in ROB_W: ROB head retiring
- `_mem_req` out 1, `_r_nw_in` out 1 (1=read), `_addr` out XLEN, `_data_in` out XLEN, `_mem_size` out 2 (0=B, 1=H, 2=W)
- `_mem_done` in 1, `_data_out` in XLEN: memory completion
- `_lsb_cdb_ready` out 1, `_lsb_cdb_rob_id` out ROB_W, `_lsb_cdb_value` out XLEN

## Operation
- Circular buffer with `head`, `tail` and `count` (width log2(DEPTH)+1).
- Per entry: valid, is_store, funct3, rob_id, addr + addr_rdy, data + data_rdy, committed.
- Allocate when `_ls_ready && !_ls_full`: write at tail and clear all ready flags. Allocation while full is ignored.
- ALU, RS and commit inputs each CAM-match rob_id across valid entries and set addr, data or committed on the matching entry. All three can land in the same cycle, on the same or different entries.
- Issue condition: head valid && addr_rdy && (load || (data_rdy && committed)) && FSM idle.
- FSM `IDLE` → `WAIT`: on issue, assert `_mem_req` and hold `_addr`, `_r_nw_in`, `_data_in` and `_mem_size` stable.
- FSM `WAIT` → `IDLE`: on `_mem_done`, pop head, drop `_mem_req`, and for a load capture the extended result.
- Load extension by funct3: 0 LB sign-extend 8, 1 LH sign-extend 16, 2 LW, 4 LBU zero-extend, 5 LHU zero-extend. Store `_mem_size` = funct3[1:0].
- `_clear`:
  - Invalidate every uncommitted entry. Tail becomes head + number of committed entries (committed stores always form a prefix from head).
  - An outstanding load completes on memory, but its CDB broadcast is suppressed.
  - An outstanding committed store completes normally.
  - Allocation in the same cycle as `_clear` is dropped.
- `_ls_full` = (count == DEPTH), computed from registered count. No same-cycle pop/push bypass.

## Timing
- Reset values: all outputs 0; FSM `IDLE`; head = tail = count = 0; all valid bits 0.
- An allocation is eligible for CAM updates from the next cycle. The ALU or RS result for that entry may not arrive in the allocation cycle.
- Issue: `_mem_req` rises the cycle after the issue condition holds.
- `_mem_done` is accepted no earlier than one cycle after `_mem_req` rises. Next issue is possible on the cycle after done.
- CDB: `_lsb_cdb_ready` is high for exactly one cycle, the cycle after `_mem_done` of a load.
- Stores produce no CDB output; they signal commit through the ROB only.
- Pointer wrap: head and tail wrap modulo DEPTH. Count distinguishes full from empty.
- `rdy_in` low in WAIT: hold the request. A `_mem_done` arriving while `rdy_in` is low is ignored, so the memory side must not assert it then.

## Structure
- Shared package `lsq_pkg`: funct3 load/store encodings, `_mem_size` encodings, FSM state enum.
- Sub-module `lsq_load_ext`: combinational funct3-driven byte/half select and extension of `_data_out`, using `_addr[1:0]` offset.

## Test plan
- Load LW rob 3, addr 0x100 from ALU → `_mem_req`=1, `_r_nw_in`=1, `_addr`=0x100. Done with 0xDEADBEEF → CDB rob 3, value 0xDEADBEEF, one cycle.
- LB addr 0x101, memory word 0x0000_8000 → CDB 0xFFFFFF80. LBU at the same address → 0x00000080.
- Store SW rob 4 with addr and data ready but uncommitted → no `_mem_req`. After commit id 4 → `_mem_req`=1, `_r_nw_in`=0.
- Fill DEPTH=4 entries → `_ls_full`=1 and a 5th alloc is ignored. Complete one → `_ls_full`=0 next cycle, and head/tail wrap correctly.
- Committed store at head, two loads behind, `_clear` → count=1 and the store still writes. A load already in WAIT at clear completes with no CDB pulse.
- ALU, RS and commit all hitting the head store in one cycle → `_mem_req` asserted the next cycle.
